pipelined_addsub: RTL

Parametrised, pipelined two's-complement adder/subtractor. It generalises the fixed 11-bit combinational ripple add/sub to any operand width. The carry chain is split into `STAGES` registered chunks, each carrying its partial carry forward, so the block can close timing on wide mantissa paths. Operands enter and results leave through valid/ready handshakes with full-throughput backpressure, and each result carries carry/borrow, signed-overflow and zero flags. It sits in the mantissa datapath of the half-precision adder, between the alignment shifter and the normaliser.

---
 rtl/pipelined_addsub_if.sv | 28 ++
 rtl/pipelined_addsub.sv | 121 ++++++++++++
 2 files changed

// File: rtl/pipelined_addsub_if.sv
// rtl/pipelined_addsub_if.sv - Operand and result handshake bundle for pipelined_addsub
interface pipelined_addsub_if #(
   parameter int WIDTH = 11
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] s;
   logic             cout;
   logic             ovf;
   logic             zero;

   // Upstream/downstream side: drives operands and result-ready
   modport master (
      output in_valid, a, b, sub, out_ready,
      input  in_ready, out_valid, s, cout, ovf, zero
   );

   // Arithmetic block side
   modport slave (
      input  in_valid, a, b, sub, out_ready,
      output in_ready, out_valid, s, cout, ovf, zero
   );
endinterface

// File: rtl/pipelined_addsub.sv
// rtl/pipelined_addsub.sv - Elastic chunked-carry two's-complement adder/subtractor
module pipelined_addsub #(
   parameter int WIDTH  = 11,
   parameter int STAGES = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   pipelined_addsub_if.slave bus
);
   // Chunk width; trailing chunks may be short or empty when WIDTH is not a multiple
   localparam int CH = (WIDTH + STAGES - 1) / STAGES;

   // Per-stage state: res holds finished sum bits low and raw A bits above
   logic [STAGES-1:0] vld_q;
   logic [WIDTH-1:0]  res_q [STAGES];
   logic [WIDTH-1:0]  opb_q [STAGES];
   logic [STAGES-1:0] cy_q;
   logic [STAGES-1:0] ovf_q;
   logic              zero_q;

   logic [STAGES-1:0] adv;
   logic [STAGES-1:0] src_vld;
   logic [STAGES-1:0] src_cy;
   logic [STAGES-1:0] src_ovf;
   logic [WIDTH-1:0]  src_res [STAGES];
   logic [WIDTH-1:0]  src_opb [STAGES];
   logic [WIDTH-1:0]  nxt_res [STAGES];
   logic [STAGES-1:0] nxt_cy;
   logic [STAGES-1:0] nxt_ovf;
   logic              nxt_zero;
   logic [WIDTH-1:0]  b_inv;

   assign b_inv = bus.b ^ {WIDTH{bus.sub}};

   // Feed of each stage: the input beat for stage 0, the previous register otherwise
   always_comb begin
      src_vld[0] = bus.in_valid;
      src_res[0] = bus.a;
      src_opb[0] = b_inv;
      src_cy[0]  = bus.sub;
      src_ovf[0] = 1'b0;
      for (int k = 1; k < STAGES; k++) begin
         src_vld[k] = vld_q[k-1];
         src_res[k] = res_q[k-1];
         src_opb[k] = opb_q[k-1];
         src_cy[k]  = cy_q[k-1];
         src_ovf[k] = ovf_q[k-1];
      end
   end

   // Ripple each stage's own chunk; overflow is resolved where the MSB is summed
   always_comb begin : chunk_add
      logic c;
      logic t;
      c = 1'b0;
      t = 1'b0;
      for (int k = 0; k < STAGES; k++) begin
         nxt_res[k] = src_res[k];
         nxt_ovf[k] = src_ovf[k];
         c = src_cy[k];
         for (int i = 0; i < WIDTH; i++) begin
            if ((i >= k * CH) && (i < (k + 1) * CH)) begin
               nxt_res[k][i] = src_res[k][i] ^ src_opb[k][i] ^ c;
               t = (src_res[k][i] & src_opb[k][i]) | (c & (src_res[k][i] ^ src_opb[k][i]));
               if (i == WIDTH - 1) begin
                  nxt_ovf[k] = c ^ t;
               end
               c = t;
            end
         end
         nxt_cy[k] = c;
      end
   end

   assign nxt_zero = (nxt_res[STAGES-1] == '0);

   // Ready chain: a stage moves when it is empty or the stage after it moves
   always_comb begin
      adv = '0;
      adv[STAGES-1] = !vld_q[STAGES-1] || bus.out_ready;
      for (int k = STAGES - 2; k >= 0; k--) begin
         adv[k] = !vld_q[k] || adv[k+1];
      end
   end

   // Stage registers; data only loads with a valid beat so the output holds when drained
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_q  <= '0;
         cy_q   <= '0;
         ovf_q  <= '0;
         zero_q <= 1'b0;
         for (int k = 0; k < STAGES; k++) begin
            res_q[k] <= '0;
            opb_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (adv[k]) begin
               vld_q[k] <= src_vld[k];
               if (src_vld[k]) begin
                  res_q[k] <= nxt_res[k];
                  opb_q[k] <= src_opb[k];
                  cy_q[k]  <= nxt_cy[k];
                  ovf_q[k] <= nxt_ovf[k];
               end
            end
         end
         if (adv[STAGES-1] && src_vld[STAGES-1]) begin
            zero_q <= nxt_zero;
         end
      end
   end

   assign bus.in_ready  = adv[0];
   assign bus.out_valid = vld_q[STAGES-1];
   assign bus.s         = res_q[STAGES-1];
   assign bus.cout      = cy_q[STAGES-1];
   assign bus.ovf       = ovf_q[STAGES-1];
   assign bus.zero      = zero_q;
endmodule
